serial_tx: RTL and testbench
============================

Name: serial_tx

Overview:
- Serial frame transmitter: accepts a parallel byte over a valid/ready handshake and shifts it out on a single line as start bit, data bits LSB-first, an optional even-parity bit, then a stop bit.
- Companion to the team's serial frame receiver/detector blocks. Sits between a producer (counter/FSM datapath) and the serial line.
- Bit timing is set by an internal clock-divider counter.

Parameters:
- DATA_W, 8, number of data bits per frame (1..16).
- CLKS_PER_BIT, 4, clk cycles each bit is held on tx. Must be ≥1; 1 is legal.
- PARITY_EN, 0, when 1 insert an even-parity bit after the data bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a byte on in_data.
- in_data  input  DATA_W  byte to send; sampled only on the accept cycle.
- in_ready  output  1  transmitter can accept; equals (state==IDLE).
- tx  output  1  serial line; idles high; registered.
- busy  output  1  high while a frame is in progress (START..STOP); registered.
- done  output  1  one-cycle pulse after the last stop-bit cycle; registered.

Behaviour:
- One clock. Reset is synchronous and active-high; the clock is clk and the reset is reset.
- Reset values: state=IDLE, tx=1, busy=0, done=0, bit counter=0, divider=0. in_ready=1 in the first cycle after reset deasserts. While reset is high, in_ready=0.
- Accept: occurs on a rising edge where in_valid & in_ready. On accept:
  - in_data is latched into the shift register; the parity bit is computed as the XOR of all latched bits.
  - The next state is START.
  - in_data/in_valid changes after accept have no effect on the frame.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1, busy=0. On accept go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx = shift_reg[0]; hold each bit CLKS_PER_BIT cycles, then shift right. After DATA_W bits go to PARITY if PARITY_EN, else STOP.
  - PARITY: tx=parity bit for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Timing from accept at edge N:
  - tx falls at edge N+1, and busy rises at the same edge.
  - Frame length F = (2 + DATA_W + PARITY_EN) × CLKS_PER_BIT cycles.
  - At edge N+1+F: state=IDLE, busy=0, done=1 for exactly one cycle, tx=1.
- Divider: counts 0..CLKS_PER_BIT-1 and resets to 0 on every bit boundary. Bit counter width is clog2(DATA_W+1). Neither counter overflows or wraps beyond its terminal value.
- Back-to-back: in_ready is high in the done cycle, so a new accept can happen there. The next start bit then begins at the following edge. Minimum inter-frame gap is one idle-high cycle (the done cycle).
- in_valid high while busy: ignored; in_ready=0; no data is lost from the producer's view.
- Reset mid-frame: the frame is aborted. At that edge: tx=1, busy=0, state=IDLE. No done pulse is issued, and the latched data is discarded.
- Reset and in_valid in the same cycle: reset wins, nothing is accepted.
- CLKS_PER_BIT=1: each state lasts one cycle per bit; the same rules apply.

Test Plan:
- DATA_W=8, CLKS_PER_BIT=4, PARITY_EN=0; send 0xA5.
  - Response: tx, in 4-cycle groups starting at accept+1, is 0,1,0,1,0,0,1,0,1,1.
  - busy is high for 40 cycles; done pulses at accept+41.
- PARITY_EN=1; send 0x07.
  - Response: 0,1,1,1,0,0,0,0,0, parity=1, stop=1. Frame is 44 cycles.
- PARITY_EN=1; send 0xA5.
  - Response: parity bit = 0.
- Hold in_valid high continuously with 0x3C then 0xC3.
  - Response: the second accept happens in the done cycle of the first frame.
  - Exactly one tx=1 idle cycle separates the two frames; the second frame decodes to 0xC3.
- Assert reset for 1 cycle during data bit 3 of 0xFF.
  - Response: next cycle tx=1, busy=0, in_ready=1, and no done pulse.
  - A following send of 0x01 transmits correctly.
- CLKS_PER_BIT=1; send 0x80 with in_valid toggling during busy.
  - Response: tx = 0,0,0,0,0,0,0,0,1,1 over 10 cycles. Only one accept occurs; done pulses at accept+11.

Source files
------------

// File: rtl/serial_tx.sv
// Serial frame transmitter: start bit, DATA_W data bits LSB-first, optional
// even parity, stop bit. Bit period is CLKS_PER_BIT clocks.
module serial_tx #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned PARITY_EN    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int unsigned     DIV_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned     CNT_W    = $clog2(DATA_W + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [CNT_W-1:0]    bit_q, bit_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                par_q, par_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                accept;
  logic                bit_end;

  assign in_ready = (state_q == IDLE) && !reset;
  assign accept   = in_valid && in_ready;
  assign bit_end  = (div_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    case (state_q)
      IDLE: begin
        div_d = '0;
        bit_d = '0;
        if (accept) begin
          shift_d = in_data;
          par_d   = ^in_data;
          state_d = START;
        end
      end
      START, PARITY, STOP: begin
        if (bit_end) begin
          div_d = '0;
          case (state_q)
            START:   state_d = DATA;
            PARITY:  state_d = STOP;
            default: state_d = IDLE;
          endcase
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          div_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_d = bit_q + CNT_W'(1);
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line outputs are registered from the present state, so tx/busy/done
  // trail the FSM by one clock: tx falls the cycle after accept.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_q != IDLE);
    done_d = busy_q && (state_q == IDLE);
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
      PARITY:  tx_d = par_q;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Scoreboard bench for serial_tx: three instances (4 clk/bit, 4 clk/bit with
// parity, 1 clk/bit) share clock and reset; expected tx streams come from a frame model.
module tb_serial_tx;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [2:0] v;
  logic [7:0] dat [3];
  logic [2:0] rdy, txs, bsy, dn;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) u0 (
    .clk(clk), .reset(reset), .in_valid(v[0]), .in_data(dat[0]),
    .in_ready(rdy[0]), .tx(txs[0]), .busy(bsy[0]), .done(dn[0]));
  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) u1 (
    .clk(clk), .reset(reset), .in_valid(v[1]), .in_data(dat[1]),
    .in_ready(rdy[1]), .tx(txs[1]), .busy(bsy[1]), .done(dn[1]));
  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(0)) u2 (
    .clk(clk), .reset(reset), .in_valid(v[2]), .in_data(dat[2]),
    .in_ready(rdy[2]), .tx(txs[2]), .busy(bsy[2]), .done(dn[2]));

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic void push_frame(int unsigned cpb, bit par_en, logic [7:0] d);
    for (int unsigned r = 0; r < cpb; r++) exp_q.push_back(1'b0);
    for (int unsigned i = 0; i < 8; i++)
      for (int unsigned r = 0; r < cpb; r++) exp_q.push_back(d[i]);
    if (par_en)
      for (int unsigned r = 0; r < cpb; r++) exp_q.push_back(^d);
    for (int unsigned r = 0; r < cpb; r++) exp_q.push_back(1'b1);
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    v = 3'b000;
    for (int i = 0; i < 3; i++) dat[i] = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if (rdy !== 3'b000) begin errors++; $display("FAIL rdy_in_reset: got %b want 000", rdy); end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (txs !== 3'b111) begin errors++; $display("FAIL reset_tx: got %b want 111", txs); end
    checks++;
    if (bsy !== 3'b000) begin errors++; $display("FAIL reset_busy: got %b want 000", bsy); end
    checks++;
    if (dn !== 3'b000) begin errors++; $display("FAIL reset_done: got %b want 000", dn); end
    checks++;
    if (rdy !== 3'b111) begin errors++; $display("FAIL reset_ready: got %b want 111", rdy); end
  endtask

  task automatic test_basic();
    int n;
    bit e;
    exp_q.delete();
    push_frame(4, 1'b0, 8'hA5);
    @(negedge clk);
    checks++;
    if (rdy[0] !== 1'b1) begin errors++; $display("FAIL basic_ready: got %b want 1", rdy[0]); end
    dat[0] = 8'hA5; v[0] = 1'b1;
    @(posedge clk); #1; v[0] = 1'b0; dat[0] = 8'h00;
    @(negedge clk);
    checks++;
    if (txs[0] !== 1'b1 || bsy[0] !== 1'b0 || rdy[0] !== 1'b0) begin
      errors++; $display("FAIL basic_accept: got tx=%b busy=%b rdy=%b want 1 0 0", txs[0], bsy[0], rdy[0]);
    end
    n = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (txs[0] !== e) begin errors++; $display("FAIL basic_tx[%0d]: got %b want %b", n, txs[0], e); end
      checks++;
      if (bsy[0] !== 1'b1 || dn[0] !== 1'b0) begin
        errors++; $display("FAIL basic_busy[%0d]: got busy=%b done=%b want 1 0", n, bsy[0], dn[0]);
      end
      n++;
    end
    @(negedge clk);
    checks++;
    if (dn[0] !== 1'b1 || bsy[0] !== 1'b0 || txs[0] !== 1'b1) begin
      errors++; $display("FAIL basic_done: got done=%b busy=%b tx=%b want 1 0 1", dn[0], bsy[0], txs[0]);
    end
    @(negedge clk);
    checks++;
    if (dn[0] !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b want 0", dn[0]); end
  endtask

  task automatic test_parity();
    logic [7:0] dtab [2];
    bit         ptab [2];
    int n;
    bit e;
    dtab[0] = 8'h07; ptab[0] = 1'b1;
    dtab[1] = 8'hA5; ptab[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      exp_q.delete();
      push_frame(4, 1'b1, dtab[k]);
      @(negedge clk);
      dat[1] = dtab[k]; v[1] = 1'b1;
      @(posedge clk); #1; v[1] = 1'b0;
      @(negedge clk);
      checks++;
      if (rdy[1] !== 1'b0) begin errors++; $display("FAIL parity_accept[%0d]: got rdy=%b want 0", k, rdy[1]); end
      n = 0;
      while (exp_q.size() > 0) begin
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (txs[1] !== e || bsy[1] !== 1'b1) begin
          errors++; $display("FAIL parity_tx[%0d][%0d]: got tx=%b busy=%b want %b 1", k, n, txs[1], bsy[1], e);
        end
        if (n == 37) begin
          checks++;
          if (txs[1] !== ptab[k]) begin errors++; $display("FAIL parity_bit[%0d]: got %b want %b", k, txs[1], ptab[k]); end
        end
        n++;
      end
      @(negedge clk);
      checks++;
      if (dn[1] !== 1'b1 || bsy[1] !== 1'b0) begin
        errors++; $display("FAIL parity_done[%0d]: got done=%b busy=%b want 1 0", k, dn[1], bsy[1]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    bit e;
    logic [7:0] dec;
    exp_q.delete();
    push_frame(4, 1'b0, 8'h3C);
    exp_q.push_back(1'b1);
    push_frame(4, 1'b0, 8'hC3);
    dec = 8'h00;
    @(negedge clk);
    dat[0] = 8'h3C; v[0] = 1'b1;
    @(posedge clk); #1; dat[0] = 8'hC3;
    @(negedge clk);
    checks++;
    if (txs[0] !== 1'b1 || rdy[0] !== 1'b0) begin
      errors++; $display("FAIL b2b_accept: got tx=%b rdy=%b want 1 0", txs[0], rdy[0]);
    end
    n = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (txs[0] !== e) begin errors++; $display("FAIL b2b_tx[%0d]: got %b want %b", n, txs[0], e); end
      checks++;
      if (dn[0] !== (n == 40) || bsy[0] !== (n != 40)) begin
        errors++; $display("FAIL b2b_flags[%0d]: got done=%b busy=%b want %b %b", n, dn[0], bsy[0], n == 40, n != 40);
      end
      if (n == 40) v[0] = 1'b0;
      if (n >= 45 && n < 77 && ((n - 45) % 4) == 1) dec[(n - 45) / 4] = txs[0];
      n++;
    end
    checks++;
    if (dec !== 8'hC3) begin errors++; $display("FAIL b2b_decode: got %h want c3", dec); end
    @(negedge clk);
    checks++;
    if (dn[0] !== 1'b1 || bsy[0] !== 1'b0 || txs[0] !== 1'b1) begin
      errors++; $display("FAIL b2b_done: got done=%b busy=%b tx=%b want 1 0 1", dn[0], bsy[0], txs[0]);
    end
    @(negedge clk);
    checks++;
    if (bsy[0] !== 1'b0 || txs[0] !== 1'b1) begin
      errors++; $display("FAIL b2b_no_third: got busy=%b tx=%b want 0 1", bsy[0], txs[0]);
    end
  endtask

  task automatic test_reset_midframe();
    int n;
    bit e;
    int done_seen;
    @(negedge clk);
    dat[0] = 8'hFF; v[0] = 1'b1;
    @(posedge clk); #1; v[0] = 1'b0;
    repeat (19) @(negedge clk);
    checks++;
    if (txs[0] !== 1'b1 || bsy[0] !== 1'b1) begin
      errors++; $display("FAIL rst_mid_bit3: got tx=%b busy=%b want 1 1", txs[0], bsy[0]);
    end
    reset = 1'b1;
    v[0] = 1'b1;
    #1;
    checks++;
    if (rdy[0] !== 1'b0) begin errors++; $display("FAIL rst_mid_ready_low: got %b want 0", rdy[0]); end
    @(posedge clk); #1; reset = 1'b0; v[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (txs[0] !== 1'b1 || bsy[0] !== 1'b0 || rdy[0] !== 1'b1 || dn[0] !== 1'b0) begin
      errors++; $display("FAIL rst_mid_after: got tx=%b busy=%b rdy=%b done=%b want 1 0 1 0", txs[0], bsy[0], rdy[0], dn[0]);
    end
    done_seen = 0;
    repeat (45) begin
      @(negedge clk);
      if (dn[0] !== 1'b0 || txs[0] !== 1'b1) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin errors++; $display("FAIL rst_mid_quiet: got %0d active cycles want 0", done_seen); end
    exp_q.delete();
    push_frame(4, 1'b0, 8'h01);
    dat[0] = 8'h01; v[0] = 1'b1;
    @(posedge clk); #1; v[0] = 1'b0;
    @(negedge clk);
    n = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (txs[0] !== e || bsy[0] !== 1'b1) begin
        errors++; $display("FAIL rst_resend_tx[%0d]: got tx=%b busy=%b want %b 1", n, txs[0], bsy[0], e);
      end
      n++;
    end
    @(negedge clk);
    checks++;
    if (dn[0] !== 1'b1) begin errors++; $display("FAIL rst_resend_done: got %b want 1", dn[0]); end
  endtask

  task automatic test_cpb1();
    int n;
    bit e;
    logic [7:0] dec;
    exp_q.delete();
    push_frame(1, 1'b0, 8'h80);
    dec = 8'h00;
    @(negedge clk);
    dat[2] = 8'h80; v[2] = 1'b1;
    @(posedge clk); #1; v[2] = 1'b0;
    @(negedge clk);
    checks++;
    if (txs[2] !== 1'b1 || rdy[2] !== 1'b0) begin
      errors++; $display("FAIL cpb1_accept: got tx=%b rdy=%b want 1 0", txs[2], rdy[2]);
    end
    n = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (txs[2] !== e || bsy[2] !== 1'b1 || dn[2] !== 1'b0) begin
        errors++; $display("FAIL cpb1_tx[%0d]: got tx=%b busy=%b done=%b want %b 1 0", n, txs[2], bsy[2], dn[2], e);
      end
      if (n >= 1 && n <= 8) dec[n - 1] = txs[2];
      v[2] = (n < 8) && ((n % 2) == 0);
      dat[2] = 8'($urandom);
      n++;
    end
    checks++;
    if (dec !== 8'h80) begin errors++; $display("FAIL cpb1_decode: got %h want 80", dec); end
    @(negedge clk);
    checks++;
    if (dn[2] !== 1'b1 || bsy[2] !== 1'b0 || txs[2] !== 1'b1) begin
      errors++; $display("FAIL cpb1_done: got done=%b busy=%b tx=%b want 1 0 1", dn[2], bsy[2], txs[2]);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (dn[2] !== 1'b0 || bsy[2] !== 1'b0 || txs[2] !== 1'b1) begin
        errors++; $display("FAIL cpb1_single_accept: got done=%b busy=%b tx=%b want 0 0 1", dn[2], bsy[2], txs[2]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_reset_midframe();
    test_cpb1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
